// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with a per-register busy scoreboard,
// optional same-cycle write-to-read bypass and a scoreboard flush.
module regfile_mp_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 4,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      iss_en,
   input  logic [NWR*AW-1:0]   iss_addr,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec
);
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d, clr, set;

   // Later ports overwrite earlier ones in loop order, so the highest index wins.
   always_comb begin
      regs_d = regs_q;
      clr = '0;
      set = '0;
      for (int i = 0; i < NWR; i++) begin
         if (wr_en[i]) begin
            regs_d[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
            clr[wr_addr[i*AW +: AW]] = 1'b1;
         end
         if (iss_en[i]) set[iss_addr[i*AW +: AW]] = 1'b1;
      end
      regs_d[0] = '0;
      clr[0] = 1'b0;
      set[0] = 1'b0;
      busy_d = flush ? '0 : (set | (busy_q & ~clr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   for (genvar j = 0; j < NRD; j++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] v;
      assign a = rd_addr[j*AW +: AW];
      always_comb begin
         v = regs_q[a];
         if (BYPASS != 0)
            for (int i = 0; i < NWR; i++)
               if (wr_en[i] && wr_addr[i*AW +: AW] == a) v = wr_data[i*XLEN +: XLEN];
      end
      assign rd_data[j*XLEN +: XLEN] = (rst || a == '0) ? '0 : v;
      assign rd_busy[j] = !rst && busy_q[a] && !clr[a];
   end
endmodule
